hs_tx_stage: RTL and testbench
==============================

Name: hs_tx_stage

Overview:
- Upstream producer stage of the handshaking interface, in the clkA domain.
- Buffers bytes from local logic in a small FIFO.
- Sends each byte across the clock boundary with a four-phase req/ack handshake to the receiving domain's capture stage.
- ack arrives asynchronously from the receiver and is synchronized internally.

Parameters:
- DATA_W, 8, width of each transferred word.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, flops in the ack synchronizer; minimum 2.

Ports:
- clkA  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  local producer offers in_data.
- in_data  input  DATA_W  word offered.
- in_ready  output  1  FIFO can accept; equals !full.
- req  output  1  four-phase request to receiver domain; registered.
- data_out  output  DATA_W  word under transfer; registered.
- ack  input  1  four-phase acknowledge from receiver domain; asynchronous to clkA.
- count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (reset=1 at a clkA edge), applied regardless of state or any in-flight handshake:
  - req=0, data_out=0, count=0, busy=0, in_ready=1.
  - FIFO pointers 0, all synchronizer flops 0, FSM=IDLE.
  - An interrupted transfer and all buffered words are discarded.
- Push: in_valid && in_ready at an edge writes in_data at the write pointer.
  - Pointers wrap modulo DEPTH.
  - in_valid while full is ignored; no overwrite.
- ack_s is the output of the SYNC_STAGES-flop chain sampling ack. The FSM uses only ack_s, never raw ack.
- Pop occurs on the edge the FSM enters REQ_HI: the head word goes to data_out and the read pointer advances.
- count: +1 on push only, -1 on pop only, unchanged when both happen in the same edge.
  - Push and pop are decided from the pre-edge count.
  - When full, in_ready=0, so no push can coincide with a full pop.
  - When empty, no pop.
- FSM states: IDLE, REQ_HI, REQ_LO.
  - IDLE -> REQ_HI when count>0 && ack_s==0. Pops; req=1 from that edge.
  - IDLE holds if ack_s==1, e.g. a stale receiver ack after reset.
  - REQ_HI holds with req=1 until ack_s==1, then -> REQ_LO with req=0.
  - REQ_LO holds with req=0 until ack_s==0. Then:
    - -> REQ_HI (pop, req=1) if count>0;
    - else -> IDLE.
- data_out is stable from the REQ_HI entry edge until the next pop; it never changes while req=1.
- Latency from push into an empty, idle block: req rises one edge after the push edge.
- Per-word cycle cost with an immediate responder: about 2*SYNC_STAGES+2 clkA cycles.
- Ordering is strict FIFO. Words are never duplicated or dropped except by reset.

Decomposition:
- Shared package hs_pkg:
  - typedef enum logic [1:0] hs_state_t {IDLE, REQ_HI, REQ_LO};
  - localparam HS_DATA_W = 8 (default source for DATA_W);
  - synchronizer depth constant HS_SYNC_STAGES = 2.
- One sub-module, hs_fifo: parameterized DATA_W/DEPTH synchronous FIFO exposing push, pop, full, empty, count, head data.
- FSM and ack synchronizer live in hs_tx_stage.

Test Plan:
- Reset/idle: hold reset 3 edges, ack=0 -> req=0, data_out=0x00, count=0, in_ready=1, busy=0.
- Single word:
  - Push 0xA5 into idle block; responder raises ack 3 cycles after seeing req and drops it 3 cycles after req falls.
  - Expected: req rises one edge after push, data_out=0xA5 while req=1, exactly one four-phase cycle, then busy=0, count=0.
- Fill/overflow:
  - Hold ack=0, push 0x01..0x06 on consecutive cycles.
  - Expected: 0x01 pops into data_out, FIFO holds 0x02..0x05 (count=4, in_ready=0), 0x06 is rejected.
  - Then run the responder: received sequence 0x01,0x02,0x03,0x04,0x05 with no 0x06.
- Back-to-back: push 0x10,0x11,0x12, then push continuously at the rate in_ready allows.
  - Expected: after each ack_s fall with count>0, req rises on the next edge with no IDLE cycle.
  - Expected: receiver order matches push order; count never exceeds 4.
- Stale ack:
  - Release reset with ack=1 and one word pushed.
  - Expected: req stays 0 until ack=0 has passed the synchronizer (SYNC_STAGES edges after ack falls), then the handshake proceeds normally.
- Reset mid-transfer:
  - Assert reset during REQ_HI with data_out=0x3C and count=2.
  - Expected: at that edge req=0, count=0, data_out=0x00, busy=0.
  - Expected: after release, a new push 0x77 transfers correctly once ack_s==0.

Source files
------------

// File: rtl/hs_pkg.sv
// Types and defaults shared by the clkA-side transmit stage of the req/ack
// handshake path.
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } hs_state_t;

  localparam int HS_DATA_W      = 8;
  localparam int HS_DEPTH       = 4;
  localparam int HS_SYNC_STAGES = 2;

  // Occupancy needs one bit more than a pointer so that "full" is representable.
  function automatic int hs_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hs_fifo.sv
// Small synchronous FIFO. The head word is visible combinationally so the
// caller can capture it on the same edge that it pops.
module hs_fifo
  import hs_pkg::*;
#(
  parameter int DATA_W = HS_DATA_W,
  parameter int DEPTH  = HS_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = hs_cnt_w(DEPTH)
) (
  input  logic              clkA,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so plain pointer overflow gives the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clkA) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clkA) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/hs_tx_stage.sv
// clkA-side producer: buffers local words and sends each one across the clock
// boundary with a four-phase req/ack handshake.
module hs_tx_stage
  import hs_pkg::*;
#(
  parameter int DATA_W      = HS_DATA_W,
  parameter int DEPTH       = HS_DEPTH,
  parameter int SYNC_STAGES = HS_SYNC_STAGES,
  localparam int CNT_W      = hs_cnt_w(DEPTH)
) (
  input  logic              clkA,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack,
  output logic [CNT_W-1:0]  count,
  output logic              busy
);

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_W-1:0]      fifo_head;
  logic                   pop;

  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                   ack_s;
  hs_state_t              state_q, state_d;
  logic                   req_q, req_d;
  logic [DATA_W-1:0]      data_q, data_d;

  hs_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clkA      (clkA),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count),
    .head      (fifo_head)
  );

  // ack is asynchronous to clkA; only the last stage of this chain is trusted.
  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack};
  end
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:    pop = !fifo_empty && !ack_s;
      REQ_HI: begin
        if (ack_s) begin
          state_d = REQ_LO;
          req_d   = 1'b0;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Every pop starts a new request; data_out only ever changes here.
    if (pop) begin
      state_d = REQ_HI;
      req_d   = 1'b1;
      data_d  = fifo_head;
    end
  end

  always_ff @(posedge clkA) begin
    if (reset) begin
      ack_sync_q <= '0;
      state_q    <= IDLE;
      req_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      ack_sync_q <= ack_sync_d;
      state_q    <= state_d;
      req_q      <= req_d;
      data_q     <= data_d;
    end
  end

  assign in_ready = !fifo_full;
  assign req      = req_q;
  assign data_out = data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_hs_tx_stage.sv
// Self-checking bench for hs_tx_stage: a scoreboard queue of accepted words is
// consumed by a four-phase responder model; vector tables and directed sequences.
module tb_hs_tx_stage;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clkA = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          req;
  logic [DW-1:0] data_out;
  logic          ack;
  logic [CW-1:0] count;
  logic          busy;

  logic          resp_en;
  logic          resp_ack;
  logic          man_ack;
  logic          b2b_mon;
  logic          req_prev;
  logic [DW-1:0] dout_prev;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            rcv_cnt  = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          vld;
    logic [DW-1:0] din;
    logic [CW-1:0] cnt;
    logic          rdy;
    logic          rq;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t tbl[7];

  always #5 clkA = ~clkA;

  assign ack = resp_en ? resp_ack : man_ack;

  hs_tx_stage #(
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clkA     (clkA),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .req      (req),
    .data_out (data_out),
    .ack      (ack),
    .count    (count),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkA);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard: a word is expected downstream when it is accepted at the next edge.
  always @(negedge clkA) begin
    if (!reset && in_valid && in_ready) exp_q.push_back(in_data);
  end

  // Running properties: data stability under req, occupancy bound, no idle gaps.
  always @(negedge clkA) begin
    if (!reset && req && req_prev) check("dout_stable", {24'd0, data_out}, {24'd0, dout_prev});
    if (!reset) check("count_le_depth", {31'd0, (count <= CW'(DEPTH))}, 32'd1);
    if (b2b_mon && count != '0) check("b2b_no_idle", {31'd0, busy}, 32'd1);
    req_prev  <= req;
    dout_prev <= data_out;
  end

  // Receiver model: ack 3 cycles after seeing req, drop 3 cycles after req falls.
  initial begin : responder
    logic [DW-1:0] e;
    int            k;
    resp_ack = 1'b0;
    forever begin
      @(negedge clkA);
      if (resp_en && !reset && req && !resp_ack) begin
        if (exp_q.size() == 0) begin
          check("rx_unexpected_word", {24'd0, data_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", {24'd0, data_out}, {24'd0, e});
        end
        rcv_cnt++;
        $display("rx word %0d: data_out=0x%02h count=%0d", rcv_cnt, data_out, count);
        repeat (3) @(posedge clkA);
        #1 resp_ack = 1'b1;
        k = 0;
        while (req && k < 200) begin
          @(negedge clkA);
          k++;
        end
        check("rx_req_fall", {31'd0, req}, 32'd0);
        repeat (3) @(posedge clkA);
        #1 resp_ack = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int            base;
    int            guard;
    logic          acc;
    logic [DW-1:0] nxt;

    tbl[0] = '{1'b1, 8'h01, 3'd1, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'h02, 3'd1, 1'b1, 1'b1, 8'h01};
    tbl[2] = '{1'b1, 8'h03, 3'd2, 1'b1, 1'b1, 8'h01};
    tbl[3] = '{1'b1, 8'h04, 3'd3, 1'b1, 1'b1, 8'h01};
    tbl[4] = '{1'b1, 8'h05, 3'd4, 1'b0, 1'b1, 8'h01};
    tbl[5] = '{1'b1, 8'h06, 3'd4, 1'b0, 1'b1, 8'h01};
    tbl[6] = '{1'b0, 8'h00, 3'd4, 1'b0, 1'b1, 8'h01};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    man_ack  = 1'b0;
    resp_en  = 1'b0;
    b2b_mon  = 1'b0;

    // Reset / idle
    do_reset();
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_dout", {24'd0, data_out}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Single word
    resp_en  = 1'b1;
    base     = rcv_cnt;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    check("sw_req_after_push", {31'd0, req}, 32'd0);
    check("sw_count_after_push", {29'd0, count}, 32'd1);
    tick();
    check("sw_req_rise", {31'd0, req}, 32'd1);
    check("sw_dout", {24'd0, data_out}, 32'h0000_00A5);
    check("sw_busy", {31'd0, busy}, 32'd1);
    check("sw_count_after_pop", {29'd0, count}, 32'd0);
    wait_idle("sw_idle_timeout");
    repeat (10) tick();
    check("sw_handshakes", rcv_cnt - base, 32'd1);
    check("sw_final_count", {29'd0, count}, 32'd0);
    check("sw_final_req", {31'd0, req}, 32'd0);

    // Fill / overflow with ack held low
    resp_en = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in_valid = tbl[i].vld;
      in_data  = tbl[i].din;
      tick();
      check($sformatf("fill[%0d].count", i), {29'd0, count}, {29'd0, tbl[i].cnt});
      check($sformatf("fill[%0d].in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].rdy});
      check($sformatf("fill[%0d].req", i), {31'd0, req}, {31'd0, tbl[i].rq});
      check($sformatf("fill[%0d].data_out", i), {24'd0, data_out}, {24'd0, tbl[i].dout});
    end
    check("fill_queued", exp_q.size(), 32'd5);
    base    = rcv_cnt;
    resp_en = 1'b1;
    wait_idle("fill_drain_timeout");
    check("fill_rx_words", rcv_cnt - base, 32'd5);
    check("fill_final_count", {29'd0, count}, 32'd0);

    // Back-to-back: push continuously as in_ready allows
    base     = rcv_cnt;
    nxt      = 8'h10;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = nxt;
    while (in_valid && guard < 2000) begin
      @(negedge clkA);
      acc = in_ready;
      tick();
      if (req) b2b_mon = 1'b1;
      if (acc) nxt = nxt + 8'd1;
      if (nxt == 8'h1C) in_valid = 1'b0;
      else              in_data  = nxt;
      guard++;
    end
    check("b2b_push_timeout", {31'd0, in_valid}, 32'd0);
    wait_idle("b2b_drain_timeout");
    b2b_mon = 1'b0;
    check("b2b_rx_words", rcv_cnt - base, 32'd12);
    check("b2b_final_count", {29'd0, count}, 32'd0);

    // Stale ack after reset
    resp_en = 1'b0;
    man_ack = 1'b1;
    do_reset();
    repeat (3) tick();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("stale[%0d].req", i), {31'd0, req}, 32'd0);
      check($sformatf("stale[%0d].busy", i), {31'd0, busy}, 32'd0);
    end
    man_ack = 1'b0;
    tick();
    check("stale_req_e1", {31'd0, req}, 32'd0);
    tick();
    check("stale_req_e2", {31'd0, req}, 32'd0);
    tick();
    check("stale_req_e3", {31'd0, req}, 32'd1);
    check("stale_dout", {24'd0, data_out}, 32'h0000_005A);
    base    = rcv_cnt;
    resp_en = 1'b1;
    wait_idle("stale_drain_timeout");
    check("stale_rx_words", rcv_cnt - base, 32'd1);

    // Reset in the middle of a transfer
    resp_en = 1'b0;
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_data = 8'h01;
    tick();
    in_data = 8'h02;
    tick();
    check("mid_req", {31'd0, req}, 32'd1);
    check("mid_dout", {24'd0, data_out}, 32'h0000_003C);
    check("mid_count", {29'd0, count}, 32'd2);
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    check("mid_rst_req", {31'd0, req}, 32'd0);
    check("mid_rst_count", {29'd0, count}, 32'd0);
    check("mid_rst_dout", {24'd0, data_out}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    reset   = 1'b0;
    resp_en = 1'b1;
    base    = rcv_cnt;
    tick();
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid_new_req", {31'd0, req}, 32'd1);
    check("mid_new_dout", {24'd0, data_out}, 32'h0000_0077);
    wait_idle("mid_drain_timeout");
    check("mid_rx_words", rcv_cnt - base, 32'd1);
    check("mid_final_count", {29'd0, count}, 32'd0);

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
